// File: rtl/prog_loader_ctrl.sv
// -----------------------------------------------------------------------------
// prog_loader_ctrl
//
// UART program loader. Listens on program_rx_i (8N1, LSB first) for the
// 4-byte preamble MAGIC, then a 32-bit little-endian word count N, then N
// little-endian data words. Each data word becomes one full-word memory write
// at BASE_ADDR + 4*index. The core is held in reset for the whole load and
// released the cycle after the single-cycle DONE state.
//
// Optional feature (macro PROG_TIMEOUT_EN): an idle-line abort. When defined,
// a counter cleared by every received byte aborts a load stuck in SIZE or
// DATA after TIMEOUT_CYCLES cycles (err_o set, no done_o). WRITE never times
// out. When undefined, no counter exists and a stalled load waits forever.
//
// Ports
//   clk_i          : the only clock, rising edge
//   rst_ni         : asynchronous active-low reset
//   program_rx_i   : programming UART line, idle high
//   prog_mode_o    : high while a load is in progress (SIZE/DATA/WRITE)
//   core_rst_no    : active-low core reset, high only in IDLE after reset
//   mem_req_o      : write request (valid)
//   mem_addr_o     : byte address of the word being written
//   mem_wdata_o    : word being written
//   mem_gnt_i      : write accepted (ready)
//   done_o         : one-cycle pulse when a load completes
//   err_o          : sticky error (framing, skid overflow, timeout);
//                    cleared when a new load enters SIZE
//   dbg_state_o    : loader FSM state
//                    0=IDLE 1=SIZE 2=DATA 3=WRITE 4=DONE
//   dbg_rx_state_o : receiver state 0=IDLE 1=START 2=DATA 3=STOP
//
// Handshake: mem_req_o is valid and mem_gnt_i is ready. A write transfers on
// the rising edge where both are high. While mem_req_o is high and mem_gnt_i
// is low, mem_addr_o and mem_wdata_o are held stable and mem_req_o stays high;
// only reset withdraws a request without a grant.
// -----------------------------------------------------------------------------
module prog_loader_ctrl #(
  parameter int unsigned CLK_DIV        = 434,
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter logic [31:0] MAGIC          = 32'h4752_534B,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        program_rx_i,
  output logic        prog_mode_o,
  output logic        core_rst_no,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  dbg_state_o,
  output logic [1:0]  dbg_rx_state_o
);

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  rx_state_e      rx_state_q, rx_state_d;
  logic           rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0]  rx_cnt_q;
  logic [2:0]     rx_bit_q;
  logic [7:0]     rx_shift_q;
  logic           rx_fall, rx_tick;
  logic           byte_stb, frame_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= program_rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;
  assign rx_tick = (rx_cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rx_state_q <= RX_IDLE;
    else         rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      // A start bit that is high again at mid-bit was a glitch.
      RX_START: if (rx_tick) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit_q == 3'd7)) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // The counter sits preloaded with the half-bit value while idle, so the
  // start bit is re-checked at mid-bit and every later sample is a full
  // bit period after that.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_cnt_q   <= HALF_LAST;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      if (rx_state_q == RX_IDLE) rx_cnt_q <= HALF_LAST;
      else if (rx_tick)          rx_cnt_q <= BIT_LAST;
      else                       rx_cnt_q <= rx_cnt_q - CW'(1);

      if (rx_tick && (rx_state_q == RX_START)) rx_bit_q <= 3'd0;
      if (rx_tick && (rx_state_q == RX_DATA)) begin
        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_q   <= rx_bit_q + 3'd1;
      end
    end
  end

  // Strobe and framing error are both raised in the stop-bit sample cycle.
  assign byte_stb  = (rx_state_q == RX_STOP) && rx_tick &&  rx_sync_q;
  assign frame_err = (rx_state_q == RX_STOP) && rx_tick && !rx_sync_q;

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SIZE  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  magic_idx_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] size_q;
  logic [31:0] word_idx_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  skid_q;
  logic        skid_vld_q;
  logic        err_q;
  logic        rst_done_q;

  logic        in_vld;
  logic [7:0]  in_byte;
  logic [7:0]  magic_byte;
  logic [31:0] size_next;
  logic        enter_size;
  logic        timeout_hit;

  // In DATA a byte parked in the skid register is consumed before the line.
  assign in_vld  = (state_q == ST_DATA) ? (skid_vld_q | byte_stb) : byte_stb;
  assign in_byte = ((state_q == ST_DATA) && skid_vld_q) ? skid_q : rx_shift_q;

  always_comb begin
    magic_byte = MAGIC[7:0];
    unique case (magic_idx_q)
      2'd0: magic_byte = MAGIC[7:0];
      2'd1: magic_byte = MAGIC[15:8];
      2'd2: magic_byte = MAGIC[23:16];
      2'd3: magic_byte = MAGIC[31:24];
      default: magic_byte = MAGIC[7:0];
    endcase
  end

  assign size_next  = {in_byte, size_q[31:8]};
  assign enter_size = (state_q == ST_IDLE) && (state_d == ST_SIZE);

`ifdef PROG_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        in_wait;

  assign in_wait = (state_q == ST_SIZE) || (state_q == ST_DATA);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  to_cnt_q <= 32'd0;
    else if (byte_stb || !in_wait) to_cnt_q <= 32'd0;
    else                          to_cnt_q <= to_cnt_q + 32'd1;
  end

  assign timeout_hit = in_wait && !byte_stb && (to_cnt_q == TIMEOUT_CYCLES - 1);
`else
  // Idle-line abort compiled out; the term only keeps TIMEOUT_CYCLES referenced.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (in_vld && (in_byte == magic_byte) && (magic_idx_q == 2'd3))
          state_d = ST_SIZE;
      ST_SIZE:
        if (timeout_hit) state_d = ST_IDLE;
        else if (in_vld && (byte_cnt_q == 2'd3))
          state_d = (size_next == 32'd0) ? ST_DONE : ST_DATA;
      ST_DATA:
        if (timeout_hit) state_d = ST_IDLE;
        else if (in_vld && (byte_cnt_q == 2'd3)) state_d = ST_WRITE;
      ST_WRITE:
        if (mem_gnt_i)
          state_d = ((word_idx_q + 32'd1) == size_q) ? ST_DONE : ST_DATA;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    prog_mode_o = 1'b0;
    mem_req_o   = 1'b0;
    done_o      = 1'b0;
    core_rst_no = 1'b0;
    unique case (state_q)
      ST_IDLE:  core_rst_no = rst_done_q;
      ST_SIZE,
      ST_DATA:  prog_mode_o = 1'b1;
      ST_WRITE: begin
        prog_mode_o = 1'b1;
        mem_req_o   = 1'b1;
      end
      ST_DONE:  done_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      magic_idx_q <= 2'd0;
      byte_cnt_q  <= 2'd0;
      size_q      <= 32'd0;
      word_idx_q  <= 32'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      skid_q      <= 8'd0;
      skid_vld_q  <= 1'b0;
      err_q       <= 1'b0;
      rst_done_q  <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (frame_err || timeout_hit) err_q <= 1'b1;

      unique case (state_q)
        ST_IDLE:
          if (in_vld) begin
            // Mismatch restarts matching; a byte equal to the first preamble
            // byte already counts as the first match. Index wraps to 0 after
            // the fourth match.
            if (in_byte == magic_byte) magic_idx_q <= magic_idx_q + 2'd1;
            else magic_idx_q <= (in_byte == MAGIC[7:0]) ? 2'd1 : 2'd0;
          end
        ST_SIZE:
          if (in_vld) begin
            size_q     <= size_next;
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        ST_DATA: begin
          if (in_vld) begin
            wdata_q    <= {in_byte, wdata_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) addr_q <= BASE_ADDR + (word_idx_q << 2);
          end
          // Skid byte consumed this cycle; a byte landing now takes its place.
          if (skid_vld_q) begin
            skid_vld_q <= byte_stb;
            skid_q     <= rx_shift_q;
          end
        end
        ST_WRITE: begin
          if (byte_stb) begin
            if (skid_vld_q) err_q <= 1'b1;
            else begin
              skid_q     <= rx_shift_q;
              skid_vld_q <= 1'b1;
            end
          end
          if (mem_gnt_i) word_idx_q <= word_idx_q + 32'd1;
        end
        default: ;
      endcase

      if (enter_size) begin
        err_q       <= 1'b0;
        magic_idx_q <= 2'd0;
        byte_cnt_q  <= 2'd0;
        size_q      <= 32'd0;
        word_idx_q  <= 32'd0;
        skid_vld_q  <= 1'b0;
      end
    end
  end

  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign err_o          = err_q;
  assign dbg_state_o    = state_q;
  assign dbg_rx_state_o = rx_state_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prog_loader_ctrl
//
// Directed + randomized bench for prog_loader_ctrl. The reference model is
// the load format itself: word i of a load lands at BASE + 4*i with the
// bytes packed first-received-least-significant; expected writes are queued
// before the bytes are sent and a monitor pops them as grants happen.
// -----------------------------------------------------------------------------
module tb_prog_loader_ctrl;

  localparam int unsigned CLK_DIV = 16;
  localparam int unsigned TO_CYC  = 1000;
  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam logic [31:0] MAGIC   = 32'h4752_534B;
  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_SIZE  = 3'd1;
  localparam logic [2:0]  S_DATA  = 3'd2;

  logic        clk, rst_n, rx, gnt;
  logic        prog_mode, core_rst_n, mem_req, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  dbg_state;
  logic [1:0]  dbg_rx_state;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int gnt_mode = 0;   // 0: tied high, 1: random, 2: held low

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  prog_loader_ctrl #(
    .CLK_DIV       (CLK_DIV),
    .BASE_ADDR     (BASE),
    .MAGIC         (MAGIC),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .program_rx_i  (rx),
    .prog_mode_o   (prog_mode),
    .core_rst_no   (core_rst_n),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_gnt_i     (gnt),
    .done_o        (done),
    .err_o         (err),
    .dbg_state_o   (dbg_state),
    .dbg_rx_state_o(dbg_rx_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- checks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  initial begin : gnt_driver
    gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
        0:       gnt = 1'b1;
        1:       gnt = 1'($urandom_range(0, 1));
        default: gnt = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin : monitor
    logic        stall_q, done_q;
    logic [31:0] a_q, d_q;
    stall_q = 1'b0;
    done_q  = 1'b0;
    a_q     = '0;
    d_q     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q = 1'b0;
        done_q  = 1'b0;
      end else begin
        if (stall_q) begin
          check1("req_held", mem_req, 1'b1);
          check("addr_held", mem_addr, a_q);
          check("wdata_held", mem_wdata, d_q);
        end
        if (done_q) check1("core_rst_after_done", core_rst_n, 1'b1);
        if (done) begin
          done_cnt++;
          check1("core_rst_in_done", core_rst_n, 1'b0);
        end
        if (mem_req && gnt) begin
          if (exp_q.size() == 0) check1("spurious_write", mem_req, 1'b0);
          else begin
            check("write_addr", mem_addr, exp_addr_q.pop_front());
            check("write_data", mem_wdata, exp_q.pop_front());
          end
        end
        stall_q = mem_req && !gnt;
        a_q     = mem_addr;
        d_q     = mem_wdata;
        done_q  = done;
      end
    end
  end

  task automatic finish_load(input int base, input string tag);
    int t;
    t = 0;
    while (done_cnt == base && t < 60 * CLK_DIV) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - base), 32'd1);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    check1({tag, "_core_rst_n"}, core_rst_n, 1'b1);
    check1({tag, "_prog_mode"}, prog_mode, 1'b0);
  endtask

  task automatic run_load(input int n, input string tag);
    logic [31:0] w;
    int base;
    base = done_cnt;
    send_word(MAGIC);
    send_word(32'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_addr_q.push_back(BASE + 32'(4 * i));
      exp_q.push_back(w);
      send_word(w);
    end
    finish_load(base, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_prog_mode"}, prog_mode, 1'b0);
    check1({tag, "_core_rst_n"}, core_rst_n, 1'b0);
    check1({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check1({tag, "_done"}, done, 1'b0);
    check1({tag, "_err"}, err, 1'b0);
    check({tag, "_state"}, {29'd0, dbg_state}, {29'd0, S_IDLE});
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [31:0] w0, w1;
    logic [7:0]  b [0:4];
    int          base, t;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    check1("core_rst_before_clk", core_rst_n, 1'b0);
    @(posedge clk);
    #1;
    check1("core_rst_first_clk", core_rst_n, 1'b1);
    @(negedge clk);

    // Two fixed words with grant tied high.
    base = done_cnt;
    exp_addr_q.push_back(BASE);        exp_q.push_back(32'h1234_5678);
    exp_addr_q.push_back(BASE + 32'd4); exp_q.push_back(32'hDEAD_BEEF);
    send_word(MAGIC);
    send_word(32'd2);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    finish_load(base, "basic");

    // Preamble preceded by a repeated first byte, empty load.
    base = done_cnt;
    send_byte(8'h4B);
    send_word(MAGIC);
    send_word(32'd0);
    finish_load(base, "overlap");

    // Random loads with random grant latency.
    gnt_mode = 1;
    for (int k = 0; k < 3; k++) run_load($urandom_range(1, 4), "rand");
    gnt_mode = 0;

    // Grant held low through two byte times during the first write.
    base = done_cnt;
    w0 = $urandom;
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
    exp_addr_q.push_back(BASE);         exp_q.push_back(w0);
    exp_addr_q.push_back(BASE + 32'd4); exp_q.push_back(pack4(b[0], b[2], b[3], b[4]));
    send_word(MAGIC);
    send_word(32'd2);
    gnt_mode = 2;
    send_word(w0);
    send_byte(b[0]);
    send_byte(b[1]);
    check1("stall_req", mem_req, 1'b1);
    check("stall_addr", mem_addr, BASE);
    check("stall_data", mem_wdata, w0);
    check1("stall_err", err, 1'b1);
    gnt_mode = 0;
    send_byte(b[2]);
    send_byte(b[3]);
    send_byte(b[4]);
    finish_load(base, "stall");
    check1("stall_err_sticky", err, 1'b1);

    // Bad stop bit while collecting the size.
    base = done_cnt;
    w1 = $urandom;
    send_word(MAGIC);
    send_byte(8'h01);
    send_byte(8'hA5, 1'b0);
    repeat (CLK_DIV) @(negedge clk);
    check1("frame_err", err, 1'b1);
    check("frame_state", {29'd0, dbg_state}, {29'd0, S_SIZE});
    check1("frame_prog_mode", prog_mode, 1'b1);
    exp_addr_q.push_back(BASE); exp_q.push_back(w1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(w1);
    finish_load(base, "frame");
    check1("frame_err_sticky", err, 1'b1);

    // Line goes idle after two data bytes.
    base = done_cnt;
    send_word(MAGIC);
    send_word(32'd1);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    repeat (TO_CYC + 100) @(negedge clk);
`ifdef PROG_TIMEOUT_EN
    check("idle_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check1("idle_err", err, 1'b1);
    check1("idle_prog_mode", prog_mode, 1'b0);
`else
    check("idle_state", {29'd0, dbg_state}, {29'd0, S_DATA});
    check1("idle_err", err, 1'b0);
    check1("idle_prog_mode", prog_mode, 1'b1);
`endif
    check("idle_no_done", 32'(done_cnt - base), 32'd0);
    pulse_reset();

    // Reset while a write is pending, then a fresh load from index 0.
    gnt_mode = 2;
    send_word(MAGIC);
    send_word(32'd1);
    send_word($urandom);
    t = 0;
    while (mem_req !== 1'b1 && t < 10 * CLK_DIV) begin
      @(negedge clk);
      t++;
    end
    check1("midrst_req_before", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gnt_mode = 0;
    @(negedge clk);
    run_load(2, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader_ctrl.md
PROG_LOADER_CTRL -- requirements
Module: prog_loader_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 434, SHALL set clock cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter BASE_ADDR, default 32'h4000_0000, SHALL set the byte address of the first loaded word.
REQ-003 Parameter MAGIC, default 32'h4752_534B, SHALL set the 4-byte load preamble, received LSB byte first ("KSRG").
REQ-004 Parameter TIMEOUT_CYCLES, default 5_000_000, SHALL set the idle-line abort limit (used only per REQ-025).
REQ-005 Port clk_i, input, 1: the only clock; all logic on its rising edge.
REQ-006 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 Port program_rx_i, input, 1: programming UART line, idle high; 8N1, LSB first.
REQ-008 Port prog_mode_o, input-free output, 1: high while a load is in progress (drives prog_mode_led_o).
REQ-009 Port core_rst_no, output, 1: active-low reset for the core and peripherals.
REQ-010 Ports mem_req_o, output, 1; mem_addr_o, output, 32; mem_wdata_o, output, 32: main-memory write request, address and data; every request is a full-word write.
REQ-011 Port mem_gnt_i, input, 1: write accepted in the cycle where mem_req_o and mem_gnt_i are both high.
REQ-012 Ports done_o, output, 1 (one-cycle pulse on load completion) and err_o, output, 1 (sticky error).

Function
REQ-013 The receiver SHALL first pass program_rx_i through a 2-flop synchronizer, then detect a falling edge, re-check low at CLK_DIV/2 cycles, and sample each data bit and the stop bit at CLK_DIV-cycle intervals after that point.
REQ-014 A start bit found high at the mid-point SHALL be ignored and the receiver SHALL return to idle with no byte.
REQ-015 A stop bit sampled low SHALL discard the byte and set err_o.
REQ-016 A valid byte SHALL raise an internal byte strobe for exactly one cycle, at the stop-bit sample cycle.
REQ-017 The FSM SHALL have the states IDLE, SIZE, DATA, WRITE and DONE.
REQ-018 IDLE SHALL compare bytes against MAGIC in byte order. On a mismatch, the match index SHALL become 1 if the byte equals MAGIC[7:0], and 0 otherwise. After the fourth matching byte the FSM SHALL enter SIZE.
REQ-019 SIZE SHALL collect 4 bytes, little-endian, into a 32-bit word count N. If N==0 it SHALL enter DONE, otherwise DATA.
REQ-020 DATA SHALL assemble 4 bytes little-endian into mem_wdata_o and SHALL then enter WRITE with mem_req_o=1 and mem_addr_o = BASE_ADDR + 4*index, with the index starting at 0.
REQ-021 In WRITE, mem_req_o, mem_addr_o and mem_wdata_o SHALL hold stable until grant. On grant the index SHALL increment and the FSM SHALL enter DONE if the new index equals N, otherwise DATA.
REQ-022 A byte arriving in WRITE SHALL be held in a 1-byte skid register and consumed first in DATA. A second byte arriving while the skid register is full SHALL be dropped and SHALL set err_o.
REQ-023 DONE SHALL last exactly one cycle with done_o=1, then the FSM SHALL enter IDLE. err_o SHALL be cleared on entry to SIZE.
REQ-024 prog_mode_o SHALL be 1 in SIZE, DATA and WRITE. core_rst_no SHALL be 0 in SIZE, DATA, WRITE and DONE and SHALL be 1 in IDLE, so the core restarts the cycle after DONE.

Configuration
REQ-025 With PROG_TIMEOUT_EN defined, a counter SHALL clear on every received byte. If it reaches TIMEOUT_CYCLES while the FSM is in SIZE or DATA, the FSM SHALL abort to IDLE, set err_o and not pulse done_o. WRITE SHALL never time out.
REQ-026 Without PROG_TIMEOUT_EN, no timeout counter SHALL exist and a stalled load SHALL remain in its state indefinitely.

Reset
REQ-027 With rst_ni low, the FSM SHALL be IDLE, the receiver idle, and prog_mode_o=0, core_rst_no=0, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, done_o=0 and err_o=0.
REQ-028 core_rst_no SHALL rise on the first clock after rst_ni deasserts. Reset mid-load SHALL abandon the load with no further memory write.

Verification
REQ-029 Bytes 4B 53 52 47, 02 00 00 00, 78 56 34 12, EF BE AD DE, with mem_gnt_i tied high -> writes 0x12345678 @0x40000000 and 0xDEADBEEF @0x40000004, then one done_o pulse, then core_rst_no=1.
REQ-030 Bytes 4B 4B 53 52 47 and N=0 -> magic accepted by the overlap rule, no mem_req_o, done_o pulses.
REQ-031 mem_gnt_i held low for 2*10*CLK_DIV cycles during the first write -> address and data stable, the first byte is taken from the skid register, the second byte is dropped, err_o=1.
REQ-032 Frame with stop bit 0 in SIZE -> byte discarded, err_o=1, the FSM stays in SIZE.
REQ-033 With PROG_TIMEOUT_EN and TIMEOUT_CYCLES=1000, the line goes idle after 2 data bytes -> IDLE and err_o=1 after 1000 cycles, no done_o. Without the macro -> the FSM stays in DATA.
REQ-034 rst_ni pulsed low in WRITE -> all outputs at reset values immediately, and the next MAGIC restarts the load at index 0.
